byte_shift_unload: RTL and testbench
====================================

Name: byte_shift_unload

Overview:
- Parallel-in, serial-out byte shift register; the transmit-side counterpart of the three-deep byte shift/tap chain.
- Accepts a word of up to NUM_BYTES bytes plus a byte count through a valid/ready handshake.
- Emits the bytes one per cycle, byte 0 first, on a valid/ready byte stream, and flags the final byte.
- Sits between a word-wide producer and a byte-wide consumer.

Parameters:
- NUM_BYTES, 3, number of byte stages in the chain; supported range 2..4.
- BYTE_W, 8, bits per byte.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer presents a word.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  NUM_BYTES*BYTE_W  word; byte 0 is in_data[BYTE_W-1:0] and is sent first.
- in_len  input  $clog2(NUM_BYTES+1)  number of valid bytes, 0..NUM_BYTES.
- out_valid  output  1  out_data holds a byte.
- out_ready  input  1  consumer takes the byte.
- out_data  output  BYTE_W  current byte.
- out_last  output  1  current byte is the last byte of the word.
- busy  output  1  a word is in flight (state SHIFT).

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low; the polarity and synchronicity are fixed.
- Reset values:
  - state=IDLE, remaining count=0, shift register=0.
  - out_valid=0, out_data=0, out_last=0, busy=0.
  - in_ready is forced 0 while rst_n is low.
- Outputs out_valid, out_data, out_last and busy are driven from registers. in_ready is combinational from state and out_ready.
- States:
  - IDLE: nothing in flight. in_ready=1.
  - SHIFT: bytes pending. in_ready = out_valid & out_ready & out_last, which allows back-to-back words.
- Accept means in_valid & in_ready at a rising edge. On accept:
  - Load the shift register with in_data.
  - Load remaining with in_len.
  - If in_len>0: next state SHIFT; out_valid=1, out_data=byte 0, out_last=(in_len==1).
  - If in_len==0: the word is consumed with no output; stay in or return to IDLE; out_valid=0.
- Latency: byte 0 appears on out_data in the cycle after acceptance.
- Transfer: on out_valid & out_ready:
  - Shift the register right by BYTE_W, filling zeros at the top.
  - Decrement remaining.
  - out_data takes the next byte; out_last asserts when remaining becomes 1.
- Last byte: when it transfers (out_last=1), go to IDLE unless a new word is accepted in the same cycle. In that case load the new word and stay in SHIFT, with no bubble.
- Stall: out_valid=1 & out_ready=0 holds out_data, out_last and remaining stable (AXI-style). out_valid never drops before its transfer.
- Input ignore rules: in_data and in_len are ignored when no accept occurs. in_len>NUM_BYTES is clamped to NUM_BYTES.
- Throughput: a NUM_BYTES-byte word every NUM_BYTES cycles with out_ready held high.
- busy = (state==SHIFT).
- Reset mid-word: the word in flight is dropped immediately, all outputs go to their reset values, and no partial byte is emitted after rst_n rises.
- Width rule: remaining has the width of in_len and never underflows; a decrement only occurs on transfer in SHIFT.

Decomposition:
- Package byte_shift_pkg holds:
  - state enum {IDLE, SHIFT}.
  - BYTE_W default constant.
  - LEN_W = $clog2(NUM_BYTES+1) helper function.
- Sub-module byte_load_stage: one BYTE_W register with async active-low reset and a load/shift/hold select, instantiated NUM_BYTES times as a chain.
- FSM and counter stay in the top.

Test Plan:
- Reset then word: rst_n low 2 cycles, then in_data=0x332211, in_len=3, out_ready=1.
  - Required: out_data 0x11, 0x22, 0x33 on 3 consecutive cycles starting the cycle after accept.
  - Required: out_last only with 0x33; busy 3 cycles.
- Back-to-back: words 0xCCBBAA/len3 then 0x0000EE/len1, in_valid held.
  - Required: output AA, BB, CC, EE with no gap.
  - Required: in_ready=1 in the CC cycle; out_last with CC and with EE.
- Backpressure: len=2 word 0x0000_5A_A5, out_ready low 3 cycles after first out_valid.
  - Required: out_data stays 0xA5 and out_valid stays 1 through the stall; then A5, 5A; in_ready=0 during the stall.
- Zero length: in_len=0 with in_data=0xFFFFFF.
  - Required: accepted in 1 cycle, out_valid stays 0, busy stays 0, next word accepted the following cycle.
- Reset mid-word: assert rst_n low after the first byte of 0x332211.
  - Required: out_valid=0 asynchronously, no 0x22/0x33 after release, in_ready=0 during reset and 1 after.
- Clamp: in_len=3 with NUM_BYTES=2, in_data=0xBEEF.
  - Required: exactly 0xEF, 0xBE emitted, out_last on 0xBE.

Source files
------------

// File: rtl/byte_shift_pkg.sv
// Shared types and helpers for the byte shift/unload block.
// Holds the FSM state enum, default byte width and length-width helper.
package byte_shift_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int DEF_BYTE_W = 8;

    // Width needed to hold a byte count of 0..n.
    function automatic int len_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/byte_load_stage.sv
// One byte register of the unload chain: parallel load, shift-in, or hold.
// Ports: clk, rst_n, load_en, shift_en, load_byte, shift_byte, q.
module byte_load_stage #(
    parameter int BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic              shift_en,
    input  logic [BYTE_W-1:0] load_byte,
    input  logic [BYTE_W-1:0] shift_byte,
    output logic [BYTE_W-1:0] q
);

    logic [BYTE_W-1:0] q_q;
    logic [BYTE_W-1:0] q_d;

    // load_en and shift_en are never both high; load wins regardless.
    always_comb begin
        q_d = q_q;
        unique case (1'b1)
            load_en:  q_d = load_byte;
            shift_en: q_d = shift_byte;
            default:  q_d = q_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/byte_shift_unload.sv
// Parallel-in, serial-out byte unloader: word + length in, bytes out, byte 0 first.
// Ports: clk, rst_n, in_valid/in_ready/in_data/in_len, out_valid/out_ready/out_data/out_last, busy.
module byte_shift_unload
    import byte_shift_pkg::*;
#(
    parameter int NUM_BYTES = 3,
    parameter int BYTE_W    = DEF_BYTE_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_BYTES*BYTE_W-1:0]   in_data,
    input  logic [len_w(NUM_BYTES)-1:0]   in_len,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BYTE_W-1:0]             out_data,
    output logic                          out_last,
    output logic                          busy
);

    localparam int LEN_W = len_w(NUM_BYTES);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(NUM_BYTES);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             busy_q, busy_d;

    logic             accept;
    logic             xfer;
    logic [LEN_W-1:0] len_c;

    logic [BYTE_W-1:0] chain_q [NUM_BYTES];

    assign xfer  = out_valid_q & out_ready;
    assign len_c = (in_len > MAX_LEN) ? MAX_LEN : in_len;

    // In SHIFT a new word may only enter as the last byte leaves.
    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            if (state_q == IDLE) begin
                in_ready = 1'b1;
            end else begin
                in_ready = out_valid_q & out_ready & out_last_q;
            end
        end
    end

    assign accept = in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        if (accept) begin
            remaining_d = len_c;
            if (len_c != '0) begin
                state_d     = SHIFT;
                out_valid_d = 1'b1;
                out_last_d  = (len_c == LEN_W'(1));
            end else begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        end else if (xfer && state_q == SHIFT) begin
            remaining_d = remaining_q - LEN_W'(1);
            if (out_last_q) begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end else begin
                out_last_d  = (remaining_q == LEN_W'(2));
            end
        end
        busy_d = (state_d == SHIFT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
        end
    end

    // Byte i shifts in byte i+1; the top stage shifts in zeros.
    for (genvar i = 0; i < NUM_BYTES; i++) begin : g_chain
        logic [BYTE_W-1:0] up;
        if (i == NUM_BYTES - 1) begin : g_top
            assign up = '0;
        end else begin : g_mid
            assign up = chain_q[i+1];
        end
        byte_load_stage #(
            .BYTE_W(BYTE_W)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .load_en   (accept),
            .shift_en  (xfer & ~accept),
            .load_byte (in_data[i*BYTE_W +: BYTE_W]),
            .shift_byte(up),
            .q         (chain_q[i])
        );
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign out_data  = chain_q[0];

endmodule

// File: tb/tb_byte_shift_unload.sv
// Directed self-checking bench for byte_shift_unload (3-byte and 2-byte builds).
module tb_byte_shift_unload;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [23:0] in_data;
    logic [1:0]  in_len;
    logic [7:0]  out_data;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_busy;
    logic [15:0] b_in_data;
    logic [1:0]  b_in_len;
    logic [7:0]  b_out_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    byte_shift_unload #(.NUM_BYTES(3), .BYTE_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_len(in_len),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy)
    );

    byte_shift_unload #(.NUM_BYTES(2), .BYTE_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_len(b_in_len),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_last(b_out_last), .busy(b_busy)
    );

    typedef struct {
        logic [23:0] data;
        logic [1:0]  len;
        int          n;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic v, input logic [7:0] d,
                           input logic l, input logic b);
        chk({nm, ".valid"}, 32'(out_valid), 32'(v));
        if (v) chk({nm, ".data"}, 32'(out_data), 32'(d));
        chk({nm, ".last"}, 32'(out_last), 32'(l));
        chk({nm, ".busy"}, 32'(busy), 32'(b));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_len = '0; out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_in_len = '0; b_out_ready = 1'b1;

        vecs[0] = '{data: 24'h332211, len: 2'd3, n: 3, exp: 32'h00332211};
        vecs[1] = '{data: 24'h0000EE, len: 2'd1, n: 1, exp: 32'h000000EE};
        vecs[2] = '{data: 24'h005AA5, len: 2'd2, n: 2, exp: 32'h00005AA5};
        vecs[3] = '{data: 24'hFFFFFF, len: 2'd0, n: 0, exp: 32'h0};
        vecs[4] = '{data: 24'h123456, len: 2'd2, n: 2, exp: 32'h00003456};

        // reset state
        step();
        step();
        chk("rst.in_ready", 32'(in_ready), 0);
        chk("rst.data", 32'(out_data), 0);
        chk_out("rst", 1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("post_rst.in_ready", 32'(in_ready), 1);

        // table-driven words, out_ready held high
        foreach (vecs[v]) begin
            in_valid = 1'b1;
            in_data  = vecs[v].data;
            in_len   = vecs[v].len;
            chk("tbl.in_ready", 32'(in_ready), 1);
            step();
            in_valid = 1'b0;
            for (int k = 0; k < vecs[v].n; k++) begin
                chk_out($sformatf("tbl%0d.b%0d", v, k), 1'b1,
                        vecs[v].exp[8*k +: 8], (k == vecs[v].n - 1), 1'b1);
                step();
            end
            chk_out($sformatf("tbl%0d.end", v), 1'b0, 8'h00, 1'b0, 1'b0);
        end

        // back-to-back words with in_valid held
        in_valid = 1'b1; in_data = 24'hCCBBAA; in_len = 2'd3;
        step();
        in_data = 24'h0000EE; in_len = 2'd1;
        chk_out("b2b.aa", 1'b1, 8'hAA, 1'b0, 1'b1);
        chk("b2b.rdy_aa", 32'(in_ready), 0);
        step();
        chk_out("b2b.bb", 1'b1, 8'hBB, 1'b0, 1'b1);
        chk("b2b.rdy_bb", 32'(in_ready), 0);
        step();
        chk_out("b2b.cc", 1'b1, 8'hCC, 1'b1, 1'b1);
        chk("b2b.rdy_cc", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        chk_out("b2b.ee", 1'b1, 8'hEE, 1'b1, 1'b1);
        step();
        chk_out("b2b.end", 1'b0, 8'h00, 1'b0, 1'b0);

        // backpressure on a 2-byte word
        in_valid = 1'b1; in_data = 24'h005AA5; in_len = 2'd2;
        step();
        in_valid = 1'b0;
        chk_out("bp.first", 1'b1, 8'hA5, 1'b0, 1'b1);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_out($sformatf("bp.stall%0d", k), 1'b1, 8'hA5, 1'b0, 1'b1);
            chk($sformatf("bp.rdy%0d", k), 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        step();
        chk_out("bp.5a", 1'b1, 8'h5A, 1'b1, 1'b1);
        step();
        chk_out("bp.end", 1'b0, 8'h00, 1'b0, 1'b0);

        // zero length word, next word the following cycle
        in_valid = 1'b1; in_data = 24'hFFFFFF; in_len = 2'd0;
        step();
        in_data = 24'h000077; in_len = 2'd1;
        chk("zl.rdy", 32'(in_ready), 1);
        chk_out("zl.none", 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        chk_out("zl.next", 1'b1, 8'h77, 1'b1, 1'b1);
        step();
        chk_out("zl.end", 1'b0, 8'h00, 1'b0, 1'b0);

        // reset in the middle of a word
        in_valid = 1'b1; in_data = 24'h332211; in_len = 2'd3;
        step();
        in_valid = 1'b0;
        chk_out("mr.first", 1'b1, 8'h11, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("mr.async", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("mr.rdy_rst", 32'(in_ready), 0);
        chk("mr.data_rst", 32'(out_data), 0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("mr.rdy_rel", 32'(in_ready), 1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk_out($sformatf("mr.quiet%0d", k), 1'b0, 8'h00, 1'b0, 1'b0);
        end

        // clamp on the 2-byte build
        b_in_valid = 1'b1; b_in_data = 16'hBEEF; b_in_len = 2'd3;
        step();
        b_in_valid = 1'b0;
        chk("cl.v0", 32'(b_out_valid), 1);
        chk("cl.d0", 32'(b_out_data), 32'hEF);
        chk("cl.l0", 32'(b_out_last), 0);
        step();
        chk("cl.v1", 32'(b_out_valid), 1);
        chk("cl.d1", 32'(b_out_data), 32'hBE);
        chk("cl.l1", 32'(b_out_last), 1);
        step();
        chk("cl.v2", 32'(b_out_valid), 0);
        chk("cl.busy2", 32'(b_busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
